// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse stretcher: state encoding, pending-counter
// ceiling and the zero-to-one length clamp.
package pulse_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_HIGH = 2'd1;
  localparam state_t ST_GAP  = 2'd2;

  localparam int PEND_W_DEF = 4;

  function automatic int pend_max(input int w);
    return (1 << w) - 1;
  endfunction

  localparam int PEND_MAX = pend_max(PEND_W_DEF);

  // A programmed length of 0 behaves like 1 so every phase lasts at least a cycle.
  function automatic int unsigned len_clamp(input int unsigned v);
    return (v == 0) ? 1 : v;
  endfunction

endpackage

// File: rtl/sat_updown_counter.sv
// Up/down counter that sticks at MAX, never wraps below zero, and holds
// when inc and dec arrive together.
module sat_updown_counter
  import pulse_pkg::*;
#(
  parameter int W   = PEND_W_DEF,
  parameter int MAX = PEND_MAX
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         sat
);

  localparam logic [W-1:0] TOP = W'(MAX);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count <= '0;
    end else if (inc && !dec && (count != TOP)) begin
      count <= count + 1'b1;
    end else if (dec && !inc && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign sat = (count == TOP);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches one-cycle strobes into H-cycle high pulses, each followed by a
// G-cycle low gap; strobes arriving while busy are queued and replayed.
module pulse_stretcher
  import pulse_pkg::*;
#(
  parameter int LEN_W  = 8,
  parameter int PEND_W = PEND_W_DEF,
  parameter int RETRIG = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              pulse_in,
  input  logic [LEN_W-1:0]  high_len,
  input  logic [LEN_W-1:0]  gap_len,
  input  logic              clr_ovf,
  output logic              level_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  state_t           state, state_n;
  logic [LEN_W-1:0] cnt, cnt_n;
  logic             level_n;
  logic [LEN_W-1:0] h_load, g_load;
  logic             last, gap_last, replay, direct;
  logic             q_inc, q_dec, pend_sat, drop;

  // cnt holds the cycles remaining after the current one, so phases load len-1.
  assign h_load   = LEN_W'(len_clamp(32'(high_len))) - LEN_W'(1);
  assign g_load   = LEN_W'(len_clamp(32'(gap_len))) - LEN_W'(1);
  assign last     = (cnt == '0);
  assign gap_last = (state == ST_GAP) && last;
  assign replay   = gap_last && (pending != '0);
  assign direct   = gap_last && (pending == '0) && pulse_in;

  assign q_inc = pulse_in && (((state == ST_HIGH) && (RETRIG == 0)) ||
                              ((state == ST_GAP) && !direct));
  assign q_dec = replay;
  assign drop  = q_inc && !q_dec && pend_sat;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    level_n = level_out;
    case (state)
      ST_IDLE: begin
        if (pulse_in) begin
          state_n = ST_HIGH;
          cnt_n   = h_load;
          level_n = 1'b1;
        end
      end
      ST_HIGH: begin
        if ((RETRIG != 0) && pulse_in) begin
          cnt_n = h_load;
        end else if (last) begin
          state_n = ST_GAP;
          cnt_n   = g_load;
          level_n = 1'b0;
        end else begin
          cnt_n = cnt - LEN_W'(1);
        end
      end
      ST_GAP: begin
        if (last) begin
          if ((pending != '0) || pulse_in) begin
            state_n = ST_HIGH;
            cnt_n   = h_load;
            level_n = 1'b1;
          end else begin
            state_n = ST_IDLE;
            cnt_n   = '0;
            level_n = 1'b0;
          end
        end else begin
          cnt_n = cnt - LEN_W'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
        level_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      level_out <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      level_out <= level_n;
      busy      <= (state_n != ST_IDLE);
    end
  end

  // A fresh drop beats a simultaneous clear.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  sat_updown_counter #(
    .W   (PEND_W),
    .MAX (pend_max(PEND_W))
  ) u_pend (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (q_inc),
    .dec   (q_dec),
    .count (pending),
    .sat   (pend_sat)
  );

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher: a per-cycle vector table for the default
// configuration plus hand sequences for retrigger, saturation and async reset.
module tb_pulse_stretcher;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       pulse_in = 1'b0;
  logic [7:0] high_len = 8'd0;
  logic [7:0] gap_len = 8'd0;
  logic       clr_ovf = 1'b0;

  logic       lvl0, busy0, ovf0;
  logic [3:0] pend0;
  logic       lvl1, busy1, ovf1;
  logic [3:0] pend1;
  logic       lvl2, busy2, ovf2;
  logic [1:0] pend2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  pulse_stretcher #(.LEN_W(8), .PEND_W(4), .RETRIG(0)) dut0 (
    .CLK(CLK), .RST(RST), .pulse_in(pulse_in), .high_len(high_len), .gap_len(gap_len),
    .clr_ovf(clr_ovf), .level_out(lvl0), .busy(busy0), .pending(pend0), .overflow(ovf0));

  pulse_stretcher #(.LEN_W(8), .PEND_W(4), .RETRIG(1)) dut1 (
    .CLK(CLK), .RST(RST), .pulse_in(pulse_in), .high_len(high_len), .gap_len(gap_len),
    .clr_ovf(clr_ovf), .level_out(lvl1), .busy(busy1), .pending(pend1), .overflow(ovf1));

  pulse_stretcher #(.LEN_W(8), .PEND_W(2), .RETRIG(0)) dut2 (
    .CLK(CLK), .RST(RST), .pulse_in(pulse_in), .high_len(high_len), .gap_len(gap_len),
    .clr_ovf(clr_ovf), .level_out(lvl2), .busy(busy2), .pending(pend2), .overflow(ovf2));

  typedef struct {
    logic       p;
    logic [7:0] hl;
    logic [7:0] gl;
    logic       clr;
    logic       el;
    logic       eb;
    logic [3:0] ep;
    logic       eo;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic p, input int hl, input int gl, input logic clr,
                     input logic el, input logic eb, input int ep, input logic eo);
    vec_t v;
    v.p = p; v.hl = 8'(hl); v.gl = 8'(gl); v.clr = clr;
    v.el = el; v.eb = eb; v.ep = 4'(ep); v.eo = eo;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    pulse_in = 1'b0;
    clr_ovf  = 1'b0;
    #2;
    RST = 1'b1;
    tick();
    #2;
    RST = 1'b0;
  endtask

  initial begin
    int rises_act, rises_exp;
    logic prev_l, prev_e;

    // Reset state of all three configurations.
    #12;
    check("rst_lvl0", int'(lvl0), 0);
    check("rst_busy0", int'(busy0), 0);
    check("rst_pend0", int'(pend0), 0);
    check("rst_ovf0", int'(ovf0), 0);
    check("rst_lvl1", int'(lvl1), 0);
    check("rst_pend2", int'(pend2), 0);
    RST = 1'b0;

    // Single strobe H=5 G=3; high_len changes mid-pulse must not matter.
    add(1, 5, 3, 0, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 1, 3, 0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 5, 3, 0, 0, 1, 0, 0);
    add(0, 5, 3, 0, 0, 0, 0, 0);
    // Zero lengths behave as one.
    add(1, 0, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    // Three back-to-back strobes, H=4 G=2: two are queued and replayed.
    add(1, 4, 2, 0, 1, 1, 0, 0);
    add(1, 4, 2, 0, 1, 1, 1, 0);
    add(1, 4, 2, 0, 1, 1, 2, 0);
    add(0, 4, 2, 0, 1, 1, 2, 0);
    add(0, 4, 2, 0, 0, 1, 2, 0);
    add(0, 4, 2, 0, 0, 1, 2, 0);
    for (int i = 0; i < 4; i++) add(0, 4, 2, 0, 1, 1, 1, 0);
    add(0, 4, 2, 0, 0, 1, 1, 0);
    add(0, 4, 2, 0, 0, 1, 1, 0);
    for (int i = 0; i < 4; i++) add(0, 4, 2, 0, 1, 1, 0, 0);
    add(0, 4, 2, 0, 0, 1, 0, 0);
    add(0, 4, 2, 0, 0, 1, 0, 0);
    add(0, 4, 2, 0, 0, 0, 0, 0);
    // Strobe on the last gap cycle with nothing queued is consumed directly.
    add(1, 2, 2, 0, 1, 1, 0, 0);
    add(0, 2, 2, 0, 1, 1, 0, 0);
    add(0, 2, 2, 0, 0, 1, 0, 0);
    add(0, 2, 2, 0, 0, 1, 0, 0);
    add(1, 2, 2, 0, 1, 1, 0, 0);
    add(0, 2, 2, 0, 1, 1, 0, 0);
    add(0, 2, 2, 0, 0, 1, 0, 0);
    add(0, 2, 2, 0, 0, 1, 0, 0);
    add(0, 2, 2, 0, 0, 0, 0, 0);
    // Strobe on the cycle a queued one replays: pending holds.
    add(1, 1, 2, 0, 1, 1, 0, 0);
    add(1, 1, 2, 0, 0, 1, 1, 0);
    add(0, 1, 2, 0, 0, 1, 1, 0);
    add(1, 1, 2, 0, 1, 1, 1, 0);
    add(0, 1, 2, 0, 0, 1, 1, 0);
    add(0, 1, 2, 0, 0, 1, 1, 0);
    add(0, 1, 2, 0, 1, 1, 0, 0);
    add(0, 1, 2, 0, 0, 1, 0, 0);
    add(0, 1, 2, 0, 0, 1, 0, 0);
    add(0, 1, 2, 0, 0, 0, 0, 0);

    rises_act = 0;
    rises_exp = 0;
    prev_l = 1'b0;
    prev_e = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      pulse_in = vecs[i].p;
      high_len = vecs[i].hl;
      gap_len  = vecs[i].gl;
      clr_ovf  = vecs[i].clr;
      tick();
      check($sformatf("vec%0d_level", i), int'(lvl0), int'(vecs[i].el));
      check($sformatf("vec%0d_busy", i), int'(busy0), int'(vecs[i].eb));
      check($sformatf("vec%0d_pending", i), int'(pend0), int'(vecs[i].ep));
      check($sformatf("vec%0d_overflow", i), int'(ovf0), int'(vecs[i].eo));
      if (lvl0 && !prev_l) rises_act++;
      if (vecs[i].el && !prev_e) rises_exp++;
      prev_l = lvl0;
      prev_e = vecs[i].el;
    end
    check("table_rising_edges", rises_act, rises_exp);

    // RETRIG=1: strobes at cycles 0, 2, 5 keep the output high through cycle 8.
    do_reset();
    high_len = 8'd4;
    gap_len  = 8'd2;
    for (int i = 0; i < 12; i++) begin
      pulse_in = (i == 0 || i == 2 || i == 5);
      tick();
      check($sformatf("retrig_c%0d_level", i), int'(lvl1), (i <= 8) ? 1 : 0);
      check($sformatf("retrig_c%0d_pending", i), int'(pend1), 0);
    end
    pulse_in = 1'b0;
    check("retrig_idle", int'(busy1), 0);

    // PEND_W=2 saturation, overflow set/clear priority, replay count.
    do_reset();
    high_len = 8'd20;
    gap_len  = 8'd1;
    rises_act = 0;
    prev_l = 1'b0;
    for (int i = 0; i < 7; i++) begin
      pulse_in = (i <= 5);
      clr_ovf  = (i == 5 || i == 6);
      tick();
      if (lvl2 && !prev_l) rises_act++;
      prev_l = lvl2;
      if (i == 3) begin
        check("sat_pend_at3", int'(pend2), 3);
        check("sat_ovf_at3", int'(ovf2), 0);
      end
      if (i == 4) check("sat_ovf_set", int'(ovf2), 1);
      if (i == 5) check("sat_set_beats_clr", int'(ovf2), 1);
      if (i == 6) begin
        check("sat_ovf_cleared", int'(ovf2), 0);
        check("sat_pend_held", int'(pend2), 3);
      end
    end
    pulse_in = 1'b0;
    clr_ovf  = 1'b0;
    begin
      int budget;
      budget = 0;
      while (busy2 && budget < 200) begin
        tick();
        budget++;
        if (lvl2 && !prev_l) rises_act++;
        prev_l = lvl2;
      end
      check("sat_timeout", (budget < 200) ? 1 : 0, 1);
    end
    check("sat_total_pulses", rises_act, 4);
    check("sat_pend_final", int'(pend2), 0);
    check("sat_ovf_final", int'(ovf2), 0);

    // Asynchronous reset mid-pulse discards the queue.
    do_reset();
    high_len = 8'd10;
    gap_len  = 8'd2;
    for (int i = 0; i < 5; i++) begin
      pulse_in = (i <= 2);
      tick();
    end
    pulse_in = 1'b0;
    check("pre_rst_pending", int'(pend0), 2);
    check("pre_rst_level", int'(lvl0), 1);
    #2;
    RST = 1'b1;
    #1;
    check("async_rst_level", int'(lvl0), 0);
    check("async_rst_busy", int'(busy0), 0);
    check("async_rst_pending", int'(pend0), 0);
    tick();
    #2;
    RST = 1'b0;
    rises_act = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (lvl0 || busy0) rises_act++;
    end
    check("post_rst_quiet", rises_act, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pulse_stretcher.md
Name: pulse_stretcher

Overview:
- Converts single-cycle strobes into a clean output level of programmable length.
- Each stretched pulse is followed by a guaranteed low gap, so a downstream edge detector sees one rising edge per input strobe.
- Strobes that arrive while an output pulse or gap is in progress are queued in a saturating pending counter and replayed in order.
- Sits between strobe-generating logic (edge detectors, event sources) and slow or level-sensitive consumers such as LEDs, external pins and cross-domain handoff.

Parameters:
- LEN_W, 8: width of the high_len and gap_len inputs and of the internal down-counter.
- PEND_W, 4: width of the pending counter; saturates at 2^PEND_W-1.
- RETRIG, 0: 0 = a strobe during HIGH is queued; 1 = a strobe during HIGH reloads the high counter (extends the pulse) and is not queued.

Ports:
- CLK  input  1  clock, rising-edge active.
- RST  input  1  reset, asynchronous, active-high.
- pulse_in  input  1  one-cycle strobe, sampled on every CLK rising edge.
- high_len  input  LEN_W  output-high duration in cycles; 0 is treated as 1.
- gap_len  input  LEN_W  mandatory low duration after each pulse; 0 is treated as 1.
- clr_ovf  input  1  clears the overflow flag.
- level_out  output  1  stretched pulse, registered.
- busy  output  1  high when state is not IDLE.
- pending  output  PEND_W  number of queued strobes not yet replayed.
- overflow  output  1  sticky flag: a strobe was dropped because pending was saturated.

Behaviour:
- Reset: asynchronous, active-high; one clock (CLK). While RST is high: state=IDLE, level_out=0, busy=0, pending=0, overflow=0, counter=0. Asserting RST mid-pulse truncates the pulse immediately and discards the queue.
- States: IDLE, HIGH, GAP. All outputs are registered. busy = (state != IDLE).
- Effective lengths: H = max(high_len,1) and G = max(gap_len,1). Both are latched when HIGH or GAP is entered; changing the inputs mid-phase has no effect until the next phase.
- IDLE -> HIGH: on pulse_in=1. Latency: level_out rises on the edge that samples pulse_in and stays high exactly H cycles.
- HIGH: the counter decrements each cycle. On the last HIGH cycle, go to GAP, so level_out drops after exactly H cycles. HIGH always goes to GAP, even when pending=0.
- GAP: level_out=0 for exactly G cycles. On the last GAP cycle:
  - if pending>0 or pulse_in=1, enter HIGH;
  - if the replay comes from the queue, pending decrements;
  - otherwise go to IDLE.
- Queuing during HIGH (RETRIG=0) or GAP (any RETRIG): each pulse_in=1 increments pending.
- Simultaneous strobe and replay: if a strobe arrives on the cycle a queued strobe is consumed, pending is unchanged (net +1 -1).
- A strobe arriving on the last GAP cycle with pending=0 is consumed directly. It does not increment pending.
- RETRIG=1 during HIGH: pulse_in reloads the counter to H. The pulse ends H cycles after the last strobe. pending is unaffected.
- Saturation: a strobe arriving when pending = 2^PEND_W-1 is dropped and overflow is set on that edge.
- clr_ovf clears overflow on the next edge. If clr_ovf and a new drop occur in the same cycle, set wins.
- Invariant: pending=0 whenever state=IDLE.

Decomposition:
- Shared package pulse_pkg holds:
  - the state encoding typedef (IDLE=2'd0, HIGH=2'd1, GAP=2'd2);
  - localparam PEND_MAX = 2^PEND_W-1;
  - the helper function for the zero-to-one length clamp.
- One natural sub-module, sat_updown_counter. It has inc and dec inputs, a count output and a sat output, saturates at the top, never underflows, and treats simultaneous inc+dec as a hold. It is instantiated for pending.

Test Plan:
- Single strobe, high_len=5, gap_len=3 -> level_out high exactly 5 cycles starting at the sampling edge; busy high for 8 cycles; pending stays 0.
- high_len=0, gap_len=0, one strobe -> 1 cycle high, 1 cycle low, then IDLE.
- RETRIG=0, high_len=4, gap_len=2, three strobes in consecutive cycles -> pending reaches 2; three 4-cycle pulses separated by 2-cycle gaps; pending returns to 0; exactly 3 rising edges.
- RETRIG=1, high_len=4, strobes at cycles 0, 2 and 5 -> level_out high cycles 0..8 continuously; pending=0.
- PEND_W=2, high_len=20, five strobes during HIGH -> pending saturates at 3 and overflow=1; 4 pulses total after the first; clr_ovf pulse clears overflow.
- RST asserted at mid-pulse with pending=2 -> level_out, pending and busy go to 0 immediately (asynchronously); no further pulses after RST deasserts.
